// File: rtl/shift_window_ctrl_pkg.sv
// Shared types and widths for the sample-window sequencer and its helpers.
package shift_window_ctrl_pkg;

    localparam int unsigned IDX_W = 3;   // decimation phase index width
    localparam int unsigned WIN_W = 4;   // window fill / hop counter width
    localparam int unsigned CNT_W = 16;  // event counter width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_e;

    // MAC handshake in flight: the start pulse or the wait for completion.
    function automatic logic is_busy(input state_e s);
        return (s == START) || (s == WAIT);
    endfunction

    // Window full: triggers are evaluated in these states.
    function automatic logic is_full(input state_e s);
        return (s == RUN) || (s == START) || (s == WAIT);
    endfunction

endpackage

// File: rtl/decim_phase_counter.sv
// Modulo-P_OSR decimation phase counter with synchronous clear and step enable.
module decim_phase_counter #(
    parameter int unsigned P_OSR = 8,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         step,
    output logic [W-1:0] index
);

    localparam logic [W-1:0] LAST_C = W'(P_OSR - 1);
    localparam logic [W-1:0] ONE_C  = W'(1);
    localparam logic [W-1:0] ZERO_C = W'(0);

    logic [W-1:0] index_r;

    // Phase register: clear wins over step, wraps from P_OSR-1 back to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_r <= ZERO_C;
        end else if (clear) begin
            index_r <= ZERO_C;
        end else if (step) begin
            if (index_r == LAST_C) begin
                index_r <= ZERO_C;
            end else begin
                index_r <= index_r + ONE_C;
            end
        end
    end

    assign index = index_r;

endmodule

// File: rtl/shift_window_ctrl.sv
// Sequencer for the IQ-demod delay line and its downstream correlator/MAC.
// Optional build macro SHIFT_WINDOW_CTRL_TRIG_CNT_EN adds trig_count and
// drop_count event counters; without it those ports do not exist.
module shift_window_ctrl
    import shift_window_ctrl_pkg::*;
#(
    parameter int unsigned P_DEPTH = 10,
    parameter int unsigned P_OSR   = 8,
    parameter int unsigned P_HOP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             adc_valid,
    output logic             data_shift_en,
    output logic [IDX_W-1:0] index,
    output logic             mac_start,
    input  logic             mac_done,
    output logic [WIN_W-1:0] win_count,
    output logic             busy,
    output logic             overrun
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
    ,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] drop_count
`endif
);

    localparam logic [WIN_W-1:0] DEPTH_C    = WIN_W'(P_DEPTH);
    localparam logic [WIN_W-1:0] DEPTH_M1_C = WIN_W'(P_DEPTH - 1);
    localparam logic [WIN_W-1:0] HOP_LAST_C = WIN_W'(P_HOP - 1);
    localparam logic [WIN_W-1:0] WIN_ONE_C  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_ZERO_C = WIN_W'(0);
    localparam logic [IDX_W-1:0] IDX_ZERO_C = IDX_W'(0);

    state_e           state_r;
    state_e           state_n;
    logic [IDX_W-1:0] index_s;
    logic [WIN_W-1:0] win_count_r;
    logic [WIN_W-1:0] hop_r;
    logic             mac_start_r;
    logic             busy_r;
    logic             overrun_r;
    logic             accept_s;
    logic             fill_done_s;
    logic             trig_s;
    logic             drop_s;

    decim_phase_counter #(
        .P_OSR (P_OSR),
        .W     (IDX_W)
    ) u_phase (
        .clk   (clk),
        .reset (reset),
        .clear (~enable),
        .step  (adc_valid & enable),
        .index (index_s)
    );

    // The line shifts on the very strobe edge; the data is aligned with adc_valid.
    assign data_shift_en = adc_valid & enable;

    // A decimated sample enters the window only on phase 0.
    assign accept_s    = adc_valid & enable & (index_s == IDX_ZERO_C);
    assign fill_done_s = accept_s & (state_r == FILL) & (win_count_r == DEPTH_M1_C);
    assign trig_s      = accept_s & is_full(state_r) & (hop_r == HOP_LAST_C);
    // A trigger is dropped unless the MAC is idle or completes in the same cycle.
    assign drop_s      = trig_s & ((state_r == START) | ((state_r == WAIT) & ~mac_done));

    // Next-state logic; disable always lands in IDLE.
    always_comb begin
        state_n = state_r;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE:  state_n = FILL;
                FILL: begin
                    if (fill_done_s) begin
                        state_n = START;
                    end else if (win_count_r == DEPTH_C) begin
                        state_n = RUN;
                    end else begin
                        state_n = FILL;
                    end
                end
                RUN: begin
                    if (trig_s) begin
                        state_n = START;
                    end else begin
                        state_n = RUN;
                    end
                end
                START: state_n = WAIT;
                WAIT: begin
                    if (mac_done) begin
                        if (trig_s) begin
                            state_n = START;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        state_n = WAIT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register with registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            mac_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            mac_start_r <= (state_n == START);
            busy_r      <= is_busy(state_n);
        end
    end

    // Window fill count, saturating at the delay-line depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_count_r <= WIN_ZERO_C;
        end else if (!enable) begin
            win_count_r <= WIN_ZERO_C;
        end else if (accept_s && (win_count_r < DEPTH_C)) begin
            win_count_r <= win_count_r + WIN_ONE_C;
        end
    end

    // Hop counter spacing MAC triggers; restarts at fill completion and on each trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hop_r <= WIN_ZERO_C;
        end else if (!enable) begin
            hop_r <= WIN_ZERO_C;
        end else if (fill_done_s || trig_s) begin
            hop_r <= WIN_ZERO_C;
        end else if (accept_s && is_full(state_r)) begin
            hop_r <= hop_r + WIN_ONE_C;
        end
    end

    // Sticky overrun flag, cleared only by reset or disable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (!enable) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end
    end

`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
    logic [CNT_W-1:0] trig_count_r;
    logic [CNT_W-1:0] drop_count_r;

    // Wrapping counters of issued MAC starts and of dropped triggers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_count_r <= CNT_W'(0);
            drop_count_r <= CNT_W'(0);
        end else if (!enable) begin
            trig_count_r <= CNT_W'(0);
            drop_count_r <= CNT_W'(0);
        end else begin
            if (state_n == START) begin
                trig_count_r <= trig_count_r + CNT_W'(1);
            end
            if (drop_s) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
        end
    end

    assign trig_count = trig_count_r;
    assign drop_count = drop_count_r;
`else
    // Event counters are not built in this configuration.
`endif

    assign index     = index_s;
    assign win_count = win_count_r;
    assign mac_start = mac_start_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Bench for shift_window_ctrl: one P_HOP=1 and one P_HOP=2 instance share
// the strobe/enable stimulus; expected mac_start cycles sit in scoreboards.
module tb_shift_window_ctrl;

    logic clk = 1'b0;
    logic reset, enable, adc_valid, md1, md2;
    logic dse1, dse2, ms1, ms2, busy1, busy2, ov1, ov2;
    logic [2:0] idx1, idx2;
    logic [3:0] wc1, wc2;
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
    logic [15:0] tc1, dc1, tc2, dc2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done1_at = -1;
    int done2_at = -1;
    int exp1_q[$];
    int exp2_q[$];
    int lat1_q[$];
    int lat2_q[$];

    always #5 clk = ~clk;

    shift_window_ctrl #(.P_DEPTH(10), .P_OSR(8), .P_HOP(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .adc_valid(adc_valid),
        .data_shift_en(dse1), .index(idx1), .mac_start(ms1), .mac_done(md1),
        .win_count(wc1), .busy(busy1), .overrun(ov1)
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        , .trig_count(tc1), .drop_count(dc1)
`endif
    );

    shift_window_ctrl #(.P_DEPTH(10), .P_OSR(8), .P_HOP(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .adc_valid(adc_valid),
        .data_shift_en(dse2), .index(idx2), .mac_start(ms2), .mac_done(md2),
        .win_count(wc2), .busy(busy2), .overrun(ov2)
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        , .trig_count(tc2), .drop_count(dc2)
`endif
    );

    // Advance one cycle, drive MAC completions, and reconcile mac_start with the scoreboards.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        md1 = (cyc == done1_at);
        md2 = (cyc == done2_at);
        if (ms1) begin
            n_cmp++;
            if (exp1_q.size() == 0) begin
                n_err++;
                $display("FAIL mac_start1_unexpected: seen in cycle %0d, none expected", cyc);
            end else begin
                e = exp1_q.pop_front();
                if (e !== cyc) begin
                    n_err++;
                    $display("FAIL mac_start1_cycle: got %0d expected %0d", cyc, e);
                end
            end
            done1_at = cyc + ((lat1_q.size() > 0) ? lat1_q.pop_front() : 3);
        end else if (exp1_q.size() > 0 && exp1_q[0] <= cyc) begin
            n_cmp++;
            n_err++;
            e = exp1_q.pop_front();
            $display("FAIL mac_start1_missing: none in cycle %0d expected at %0d", cyc, e);
        end
        if (ms2) begin
            n_cmp++;
            if (exp2_q.size() == 0) begin
                n_err++;
                $display("FAIL mac_start2_unexpected: seen in cycle %0d, none expected", cyc);
            end else begin
                e = exp2_q.pop_front();
                if (e !== cyc) begin
                    n_err++;
                    $display("FAIL mac_start2_cycle: got %0d expected %0d", cyc, e);
                end
            end
            done2_at = cyc + ((lat2_q.size() > 0) ? lat2_q.pop_front() : 3);
        end else if (exp2_q.size() > 0 && exp2_q[0] <= cyc) begin
            n_cmp++;
            n_err++;
            e = exp2_q.pop_front();
            $display("FAIL mac_start2_missing: none in cycle %0d expected at %0d", cyc, e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({ms1, busy1, ov1} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {ms1, busy1, ov1}); end
        n_cmp++; if (wc1 !== 4'd0) begin n_err++; $display("FAIL reset_win_count: got %0d expected 0", wc1); end
        n_cmp++; if (idx1 !== 3'd0) begin n_err++; $display("FAIL reset_index: got %0d expected 0", idx1); end
        reset = 1'b0;
    endtask

    task automatic test_idle_strobe();
        adc_valid = 1'b1;
        enable    = 1'b0;
        #1;
        n_cmp++; if ({dse1, dse2} !== 2'b00) begin n_err++; $display("FAIL shift_en_disabled: got %b expected 00", {dse1, dse2}); end
        repeat (3) tick();
        n_cmp++; if (idx1 !== 3'd0 || wc1 !== 4'd0) begin n_err++; $display("FAIL idle_hold: index %0d win %0d expected 0 0", idx1, wc1); end
        enable    = 1'b1;
        adc_valid = 1'b0;
        #1;
        n_cmp++; if (dse1 !== 1'b0) begin n_err++; $display("FAIL shift_en_no_strobe: got %b expected 0", dse1); end
        repeat (3) tick();
        n_cmp++; if (idx1 !== 3'd0 || wc1 !== 4'd0 || busy1 !== 1'b0) begin n_err++; $display("FAIL no_strobe_hold: index %0d win %0d busy %b expected 0 0 0", idx1, wc1, busy1); end
    endtask

    task automatic test_fill();
        int exp_wc;
        cyc = 0;
        adc_valid = 1'b1;
        exp1_q.push_back(73);
        exp2_q.push_back(73);
        lat1_q = {5, 7, 20};
        lat2_q = {5};
        for (int c = 0; c <= 80; c++) begin
            if (c > 0) tick(); else #1;
            exp_wc = (c == 0) ? 0 : (((c + 7) / 8 > 10) ? 10 : (c + 7) / 8);
            n_cmp++; if (idx1 !== 3'(c % 8)) begin n_err++; $display("FAIL fill_index c=%0d: got %0d expected %0d", c, idx1, c % 8); end
            n_cmp++; if (dse1 !== 1'b1) begin n_err++; $display("FAIL fill_shift_en c=%0d: got %b expected 1", c, dse1); end
            n_cmp++; if (wc1 !== 4'(exp_wc) || wc2 !== 4'(exp_wc)) begin n_err++; $display("FAIL fill_win_count c=%0d: got %0d/%0d expected %0d", c, wc1, wc2, exp_wc); end
            if (c == 78) begin n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL busy_wait: got %b expected 1", busy1); end end
            if (c == 79) begin n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL busy_after_done: got %b expected 0", busy1); end end
        end
    endtask

    task automatic test_hop_overrun();
        // DUT1 (hop 1): 81, 89 (trigger coincides with done at 88), drops at 96/104, done at 109.
        // DUT2 (hop 2): one start every 16 cycles, MAC answers in 3.
        exp1_q.push_back(81); exp1_q.push_back(89); exp1_q.push_back(113);
        exp1_q.push_back(121); exp1_q.push_back(129);
        exp2_q.push_back(89); exp2_q.push_back(105); exp2_q.push_back(121);
        while (cyc < 130) begin
            tick();
            if (cyc == 89 || cyc == 96) begin n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL overrun_coincident c=%0d: got %b expected 0", cyc, ov1); end end
            if (cyc == 97) begin
                n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", ov1); end
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
                n_cmp++; if (tc1 !== 16'd3 || dc1 !== 16'd1) begin n_err++; $display("FAIL counts_3_1: got %0d/%0d expected 3/1", tc1, dc1); end
`endif
            end
            if (cyc == 108) begin n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL busy_withheld: got %b expected 1", busy1); end end
            if (cyc == 110) begin n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL busy_release: got %b expected 0", busy1); end end
            if (cyc == 120) begin n_cmp++; if (wc1 !== 4'd10 || wc2 !== 4'd10) begin n_err++; $display("FAIL win_saturate: got %0d/%0d expected 10", wc1, wc2); end end
        end
        n_cmp++; if (ov2 !== 1'b0 || ov1 !== 1'b1) begin n_err++; $display("FAIL overrun_final: got %b/%b expected 1/0", ov1, ov2); end
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        n_cmp++; if (tc1 !== 16'd6 || dc1 !== 16'd2 || tc2 !== 16'd4 || dc2 !== 16'd0) begin n_err++; $display("FAIL counts_run: got %0d/%0d %0d/%0d expected 6/2 4/0", tc1, dc1, tc2, dc2); end
`endif
    endtask

    task automatic test_disable();
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL pre_disable_wait: got %b expected 1", busy1); end
        enable = 1'b0;
        #1;
        n_cmp++; if (dse1 !== 1'b0) begin n_err++; $display("FAIL disable_shift_en: got %b expected 0", dse1); end
        tick();
        n_cmp++; if (idx1 !== 3'd0 || idx2 !== 3'd0) begin n_err++; $display("FAIL disable_index: got %0d/%0d expected 0", idx1, idx2); end
        n_cmp++; if (wc1 !== 4'd0 || wc2 !== 4'd0) begin n_err++; $display("FAIL disable_win: got %0d/%0d expected 0", wc1, wc2); end
        n_cmp++; if (ov1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL disable_flags: overrun %b busy %b expected 0 0", ov1, busy1); end
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        n_cmp++; if (tc1 !== 16'd0 || dc1 !== 16'd0) begin n_err++; $display("FAIL disable_counts: got %0d/%0d expected 0/0", tc1, dc1); end
`endif
        while (cyc < 139) tick();
        n_cmp++; if (busy1 !== 1'b0 || wc1 !== 4'd0 || idx1 !== 3'd0) begin n_err++; $display("FAIL late_done_ignored: busy %b win %0d index %0d expected 0 0 0", busy1, wc1, idx1); end
    endtask

    task automatic test_refill();
        tick();
        enable = 1'b1;
        exp1_q.push_back(213);
        exp2_q.push_back(213);
        while (cyc < 217) begin
            tick();
            if (cyc == 141) begin n_cmp++; if (idx1 !== 3'd1) begin n_err++; $display("FAIL refill_index: got %0d expected 1", idx1); end end
            if (cyc == 205) begin n_cmp++; if (wc1 !== 4'd9 || wc2 !== 4'd9) begin n_err++; $display("FAIL refill_nine: got %0d/%0d expected 9", wc1, wc2); end end
            if (cyc == 212) begin n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL refill_not_busy: got %b expected 0", busy1); end end
            if (cyc == 213) begin n_cmp++; if (wc1 !== 4'd10) begin n_err++; $display("FAIL refill_full: got %0d expected 10", wc1); end end
        end
        n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL refill_done: got %b/%b expected 0", busy1, busy2); end
    endtask

    task automatic test_async_reset();
        n_cmp++; if (wc1 !== 4'd10 || idx1 !== 3'd5) begin n_err++; $display("FAIL pre_reset_state: win %0d index %0d expected 10 5", wc1, idx1); end
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        n_cmp++; if (tc1 !== 16'd1) begin n_err++; $display("FAIL pre_reset_trig: got %0d expected 1", tc1); end
`endif
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (wc1 !== 4'd0 || idx1 !== 3'd0 || wc2 !== 4'd0) begin n_err++; $display("FAIL async_reset_counts: win %0d index %0d win2 %0d expected 0", wc1, idx1, wc2); end
        n_cmp++; if ({ms1, busy1, ov1} !== 3'b000) begin n_err++; $display("FAIL async_reset_flags: got %b expected 000", {ms1, busy1, ov1}); end
`ifdef SHIFT_WINDOW_CTRL_TRIG_CNT_EN
        n_cmp++; if (tc1 !== 16'd0 || dc1 !== 16'd0) begin n_err++; $display("FAIL async_reset_trig: got %0d/%0d expected 0/0", tc1, dc1); end
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        adc_valid = 1'b0;
        md1       = 1'b0;
        md2       = 1'b0;
        test_reset();
        test_idle_strobe();
        test_fill();
        test_hop_overrun();
        test_disable();
        test_refill();
        test_async_reset();
        n_cmp++; if (exp1_q.size() != 0 || exp2_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: left %0d/%0d expected 0", exp1_q.size(), exp2_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
